pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush/redirect controller for the 5-stage RISC-V pipeline. It drives the write-enable and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers from three sources:
- load-use hazards detected in ID;
- taken branch/JAL/JALR redirects resolved in MEM;
- data-memory wait handshakes.

It also holds the pipeline after reset and optionally counts stall and flush events.

## Interface
Parameters:
- RESET_HOLD, 2: cycles the pipeline is held flushed after reset release; legal range 1..255.
- MEM_TIMEOUT, 16: maximum wait cycles before a forced release; legal range 2..255.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1 each  ID instruction reads rs1 / rs2.
- ex_rd  in  5  destination register in EX.
- ex_mem_read  in  1  EX instruction is a load.
- mem_redirect  in  1  MEM instruction is a taken branch, JAL or JALR.
- mem_redirect_sel  in  2  redirect kind: 1 = branch, 2 = JAL, 3 = JALR.
- dmem_req  in  1  MEM instruction accesses data memory.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_sel  out  2  next-PC select: 0 = PC+4, 1 = branch target, 2 = JAL target, 3 = JALR target.
- pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we  out  1 each  register load enables.
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  load a bubble (all zeros) on the next edge.
- mem_timeout  out  1  one-cycle pulse when a memory wait is force-released.
- stall_cycles  out  32  stall cycle count (only with the configuration macro).
- flush_events  out  32  redirect count (only with the configuration macro).

## Operation
- State register: INIT, RUN, MEM_WAIT. A wait counter `wcnt` of 8 bits.
- All enable/flush/pc_sel outputs are combinational from the current state and inputs. Default: every `*_we` = 1, every flush = 0, pc_sel = 0.
- INIT:
  - All `*_we` = 0 and all flushes = 1.
  - `wcnt` counts 0..RESET_HOLD-1, then the next state is RUN.
- RUN rules, highest priority first:
  1. Memory stall, when dmem_req & !dmem_ready:
     - all `*_we` = 0, mem_wb_flush = 1, redirect ignored;
     - next state MEM_WAIT, `wcnt` = 1.
  2. Redirect, when mem_redirect:
     - pc_sel = mem_redirect_sel, pc_we = 1;
     - if_id_flush, id_ex_flush and ex_mem_flush = 1;
     - load-use ignored, because the ID instruction is being flushed.
  3. Load-use, when all of the following hold:
     - ex_mem_read, and ex_rd != 0;
     - (id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd).
     Response: pc_we = 0, if_id_we = 0, id_ex_flush = 1. One bubble only; forwarding covers the rest.
- MEM_WAIT:
  - While !dmem_ready and `wcnt` < MEM_TIMEOUT: same stall outputs as rule 1, `wcnt` increments.
  - On dmem_ready: outputs follow RUN rules 2–3 in the same cycle, next state RUN, `wcnt` cleared.
  - If `wcnt` == MEM_TIMEOUT and !dmem_ready: release as if ready, register mem_timeout = 1 for the following cycle, next state RUN.
- A dmem_req that drops during MEM_WAIT is treated as ready.

## Timing
- Reset values:
  - state = INIT, `wcnt` = 0;
  - mem_timeout = 0, stall_cycles = 0, flush_events = 0;
  - hence all `*_we` = 0, all flushes = 1, pc_sel = 0.
- The first RUN cycle follows exactly RESET_HOLD clk edges after reset deasserts.
- Redirect has zero latency: the target is loaded into the PC on the same edge that the three flushes take effect.
- A load-use stall costs exactly 1 cycle. A memory stall costs N cycles, where N is the number of !dmem_ready cycles, capped at MEM_TIMEOUT.
- mem_timeout is high for exactly 1 cycle, the cycle after the forced release.
- Reset asserted mid-wait or mid-hold returns to INIT immediately (asynchronously), with outputs as listed above.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cycles increments on every cycle with pc_we = 0 in RUN or MEM_WAIT;
  - flush_events increments on every accepted redirect;
  - both wrap at 2^32.
- HAZARD_PERF_CNT_EN undefined: no counter registers; stall_cycles and flush_events are tied to 0.

## Test plan
- Reset hold: reset low 3 cycles then high, RESET_HOLD = 2 -> outputs stay at INIT values (all `*_we` 0, flushes 1) for 2 edges; pc_we = 1 from the 3rd cycle.
- Load-use: ex_mem_read = 1, ex_rd = 5, id_rs2 = 5, id_uses_rs2 = 1 -> one cycle with pc_we = 0, if_id_we = 0, id_ex_flush = 1. Repeating with ex_rd = 0 gives no stall.
- Redirect: mem_redirect = 1, mem_redirect_sel = 3, with a concurrent load-use -> pc_sel = 3, pc_we = 1, three flushes = 1, no load-use stall; flush_events goes 0 -> 1 with the macro.
- Memory wait: dmem_req = 1 with dmem_ready low for 4 cycles -> all `*_we` 0 for 4 cycles, then resume on the ready cycle; stall_cycles = 4.
- Timeout: dmem_ready held low, MEM_TIMEOUT = 16 -> release after 16 stall cycles, mem_timeout pulses for 1 cycle, state RUN.
- Reset while in MEM_WAIT -> outputs return to INIT values immediately, `wcnt` = 0, counters cleared.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// +--------------------------------------------------------------------------+
// | pipe_hazard_ctrl: stall/flush/redirect control for the 5-stage pipeline.  |
// | Optional event counters enabled by macro HAZARD_PERF_CNT_EN.              |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module pipe_hazard_ctrl #(
  parameter int RESET_HOLD  = 2,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        mem_redirect,
  input  logic [1:0]  mem_redirect_sel,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic [1:0]  pc_sel,
  output logic        pc_we,
  output logic        if_id_we,
  output logic        id_ex_we,
  output logic        ex_mem_we,
  output logic        mem_wb_we,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        mem_wb_flush,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);

  localparam logic [7:0] C_HOLD_LAST   = 8'(RESET_HOLD - 1);
  localparam logic [7:0] C_MEM_TIMEOUT = 8'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_wcnt, w_wcnt_nxt;
  logic       r_mem_timeout, w_timeout_set;
  logic       w_mem_stall, w_wait_ready, w_load_use, w_run_rules;

  assign w_mem_stall  = dmem_req & ~dmem_ready;
  // A request withdrawn mid-wait releases the stall just like a ready.
  assign w_wait_ready = dmem_ready | ~dmem_req;
  assign w_load_use   = ex_mem_read && (ex_rd != 5'd0) &&
                        ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                         (id_uses_rs2 && (id_rs2 == ex_rd)));
  assign w_run_rules  = ((r_state == ST_RUN) && !w_mem_stall) ||
                        ((r_state == ST_MEM_WAIT) &&
                         (w_wait_ready || (r_wcnt >= C_MEM_TIMEOUT)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_INIT;
      r_wcnt        <= 8'd0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wcnt        <= w_wcnt_nxt;
      r_mem_timeout <= w_timeout_set;
    end
  end

  always_comb begin
    pc_sel        = 2'd0;
    pc_we         = 1'b1;
    if_id_we      = 1'b1;
    id_ex_we      = 1'b1;
    ex_mem_we     = 1'b1;
    mem_wb_we     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    mem_wb_flush  = 1'b0;
    w_state_nxt   = r_state;
    w_wcnt_nxt    = r_wcnt;
    w_timeout_set = 1'b0;

    case (r_state)
      ST_INIT: begin
        {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 5'b00000;
        {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush} = 4'b1111;
        if (r_wcnt >= C_HOLD_LAST) begin
          w_state_nxt = ST_RUN;
          w_wcnt_nxt  = 8'd0;
        end else begin
          w_wcnt_nxt  = r_wcnt + 8'd1;
        end
      end
      ST_RUN: begin
        if (w_mem_stall) begin
          {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 5'b00000;
          mem_wb_flush = 1'b1;
          w_state_nxt  = ST_MEM_WAIT;
          w_wcnt_nxt   = 8'd1;
        end
      end
      ST_MEM_WAIT: begin
        if (!w_run_rules) begin
          {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 5'b00000;
          mem_wb_flush = 1'b1;
          w_wcnt_nxt   = r_wcnt + 8'd1;
        end else begin
          w_state_nxt   = ST_RUN;
          w_wcnt_nxt    = 8'd0;
          w_timeout_set = ~w_wait_ready;
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
        w_wcnt_nxt  = 8'd0;
      end
    endcase

    // Redirect outranks load-use: the dependent ID instruction is flushed anyway.
    if (w_run_rules) begin
      if (mem_redirect) begin
        pc_sel       = mem_redirect_sel;
        pc_we        = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (w_load_use) begin
        pc_we        = 1'b0;
        if_id_we     = 1'b0;
        id_ex_flush  = 1'b1;
      end
    end
  end

  assign mem_timeout = r_mem_timeout;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cycles, r_flush_events;
  logic        w_stall_cycle, w_redirect_taken;

  assign w_stall_cycle    = (r_state != ST_INIT) && !pc_we;
  assign w_redirect_taken = w_run_rules && mem_redirect;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cycles <= 32'd0;
      r_flush_events <= 32'd0;
    end else begin
      if (w_stall_cycle)    r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_redirect_taken) r_flush_events <= r_flush_events + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;
`else
  assign stall_cycles = 32'd0;
  assign flush_events = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_pipe_hazard_ctrl: directed scoreboard bench for pipe_hazard_ctrl.      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pipe_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit c_perf = 1'b1;
`else
  localparam bit c_perf = 1'b0;
`endif

  // {pc_sel, pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
  //  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, mem_timeout}
  localparam logic [11:0] V_INIT  = {2'd0, 5'b00000, 4'b1111, 1'b0};
  localparam logic [11:0] V_NORM  = {2'd0, 5'b11111, 4'b0000, 1'b0};
  localparam logic [11:0] V_LU    = {2'd0, 5'b00111, 4'b0100, 1'b0};
  localparam logic [11:0] V_STALL = {2'd0, 5'b00000, 4'b0001, 1'b0};
  localparam logic [11:0] V_TOUT  = {2'd0, 5'b11111, 4'b0000, 1'b1};
  localparam logic [11:0] V_RED1  = {2'd1, 5'b11111, 4'b1110, 1'b0};
  localparam logic [11:0] V_RED2  = {2'd2, 5'b11111, 4'b1110, 1'b0};
  localparam logic [11:0] V_RED3  = {2'd3, 5'b11111, 4'b1110, 1'b0};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic        id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, ex_mem_read = 1'b0;
  logic        mem_redirect = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;
  logic [1:0]  mem_redirect_sel = 2'd0;
  logic [1:0]  pc_sel;
  logic        pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, mem_timeout;
  logic [31:0] stall_cycles, flush_events;

  pipe_hazard_ctrl #(.RESET_HOLD(2), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .mem_redirect(mem_redirect), .mem_redirect_sel(mem_redirect_sel),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_sel(pc_sel), .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we),
    .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  logic [11:0] obs_vec;
  assign obs_vec = {pc_sel, pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
                    if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, mem_timeout};

  typedef struct {
    string       tag;
    logic [11:0] v;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_stall = 32'd0;
  logic [31:0] exp_flush = 32'd0;

  task automatic pop_and_check();
    exp_t        e;
    logic [31:0] es, ef;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h required an entry", obs_vec);
      return;
    end
    e = exp_q.pop_front();
    assert (obs_vec === e.v) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", e.tag, obs_vec, e.v);
    end
    es = c_perf ? exp_stall : 32'd0;
    ef = c_perf ? exp_flush : 32'd0;
    n_tests++;
    assert (stall_cycles === es) else begin
      n_fail++;
      $error("FAIL %s_stall_cycles: observed %0d expected %0d", e.tag, stall_cycles, es);
    end
    n_tests++;
    assert (flush_events === ef) else begin
      n_fail++;
      $error("FAIL %s_flush_events: observed %0d expected %0d", e.tag, flush_events, ef);
    end
  endtask

  // One cycle: expectation queued with the stimulus, checked at the falling edge.
  task automatic step(input string tag, input logic [11:0] v, input bit in_init);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    exp_q.push_back(e);
    @(negedge clk);
    pop_and_check();
    if (!in_init && !v[9])          exp_stall = exp_stall + 32'd1;
    if (!in_init && v[4:2] == 3'b111) exp_flush = exp_flush + 32'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
    mem_redirect = 1'b0; mem_redirect_sel = 2'd0;
    dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  initial begin
    exp_t e;
    #1;
    for (int i = 0; i < 3; i++) step("reset_low", V_INIT, 1'b1);
    reset = 1'b1;
    step("hold0", V_INIT, 1'b1);
    step("hold1", V_INIT, 1'b1);
    step("first_run", V_NORM, 1'b0);

    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    step("load_use_rs2", V_LU, 1'b0);
    ex_mem_read = 1'b0;
    step("after_bubble", V_NORM, 1'b0);
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0;
    step("load_use_x0", V_NORM, 1'b0);
    ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b0; id_rs2 = 5'd3;
    step("load_use_rs1", V_LU, 1'b0);
    id_uses_rs1 = 1'b0;
    step("match_unused", V_NORM, 1'b0);

    id_uses_rs1 = 1'b1; mem_redirect = 1'b1; mem_redirect_sel = 2'd3;
    step("redirect_jalr", V_RED3, 1'b0);
    clear_inputs();
    mem_redirect = 1'b1; mem_redirect_sel = 2'd1;
    step("redirect_br", V_RED1, 1'b0);
    clear_inputs();
    step("idle", V_NORM, 1'b0);

    dmem_req = 1'b1; mem_redirect = 1'b1; mem_redirect_sel = 2'd2;
    for (int i = 0; i < 4; i++) step("mem_wait", V_STALL, 1'b0);
    dmem_ready = 1'b1;
    step("mem_ready_jal", V_RED2, 1'b0);
    clear_inputs();
    step("mem_done", V_NORM, 1'b0);

    dmem_req = 1'b1;
    for (int i = 0; i < 16; i++) step("tmo_wait", V_STALL, 1'b0);
    step("tmo_release", V_NORM, 1'b0);
    dmem_req = 1'b0;
    step("tmo_pulse", V_TOUT, 1'b0);
    step("tmo_clear", V_NORM, 1'b0);

    dmem_req = 1'b1;
    step("drop_wait", V_STALL, 1'b0);
    dmem_req = 1'b0;
    step("drop_release", V_NORM, 1'b0);

    dmem_req = 1'b1;
    step("rst_wait0", V_STALL, 1'b0);
    step("rst_wait1", V_STALL, 1'b0);
    reset = 1'b0;
    exp_stall = 32'd0;
    exp_flush = 32'd0;
    #1;
    e.tag = "async_reset";
    e.v   = V_INIT;
    exp_q.push_back(e);
    pop_and_check();
    clear_inputs();
    @(posedge clk);
    #1;
    reset = 1'b1;
    step("rehold0", V_INIT, 1'b1);
    step("rehold1", V_INIT, 1'b1);
    step("rerun", V_NORM, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench did not complete");
  end

endmodule

`default_nettype wire
